// File: rtl/pri_enc_pkg.sv
// Shared constants and helpers for the sequential priority encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro: ROUND_ROBIN_EN selects the rotating-priority build.
package pri_enc_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = $clog2(N_DEF);

    localparam int PRI_FIXED = 0;
    localparam int PRI_RR    = 1;

`ifdef ROUND_ROBIN_EN
    localparam int PRI_MODE = PRI_RR;
`else
    localparam int PRI_MODE = PRI_FIXED;
`endif

    // Binary index of a one-hot vector (up to 32 lines). For an all-zero
    // input the result is 0.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pri_sel.sv
// Combinational selector: picks the first set bit of cand searching start, start-1, ... (wrapping).
// Latency: purely combinational, zero cycles.
// Backpressure: none, no state.
// Ports: cand = candidate lines, start = highest-priority position,
//        any = some candidate set, idx = binary index of the winner.
module pri_sel
    import pri_enc_pkg::*;
#(
    parameter  int N = N_DEF,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] cand,
    input  logic [W-1:0] start,
    output logic         any,
    output logic [W-1:0] idx
);

    logic [N-1:0] grant;
    logic [W-1:0] pos;

    // Walk from lowest to highest priority so the last hit (position start)
    // overrides everything before it. N is a power of two, so the W-bit
    // subtraction wraps modulo N for free.
    always_comb begin
        grant = '0;
        pos   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = start - W'(i);
            if (cand[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
            end
        end
    end

    assign any = |cand;
    assign idx = W'(onehot_to_idx(32'(grant)));

endmodule

// File: rtl/pri_enc_seq.sv
// Sequential priority encoder: latches request pulses, issues the winning index on a valid/ready port.
// Latency: req at cycle t -> pending at edge t+1 -> out_valid/out_code after edge t+2 when idle.
// Backpressure: with out_valid=1 and out_ready=0 the output holds; new requests accumulate in pending.
// Ports: clk, rst_n (sync, active low), req[N], out_valid/out_ready/out_code[W],
//        pending[N] (status), busy (pending non-empty or output valid).
// Optional feature macro: ROUND_ROBIN_EN (rotating priority via rr_ptr); default is fixed,
// highest index wins.
module pri_enc_seq
    import pri_enc_pkg::*;
#(
    parameter  int N = N_DEF,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_code,
    output logic [N-1:0] pending,
    output logic         busy
);

    logic         accept;
    logic         load_en;
    logic         sel_any;
    logic [W-1:0] sel_idx;
    logic [W-1:0] start;
    logic [N-1:0] acc_mask;
    logic [N-1:0] cand;
    logic [N-1:0] retire;

    assign accept  = out_valid & out_ready;
    // out_valid is the IDLE/HOLD state: load when empty or being drained.
    assign load_en = ~out_valid | accept;

    // A code being accepted this cycle must not be reissued on the same edge,
    // even if it was re-requested while in flight.
    always_comb begin
        acc_mask = '0;
        if (accept) acc_mask[out_code] = 1'b1;
    end

    assign cand = pending & ~acc_mask;

    // Pending bits retire when loaded into the output, not when accepted.
    always_comb begin
        retire = '0;
        if (load_en && sel_any) retire[sel_idx] = 1'b1;
    end

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] rr_ptr;

    // Search begins just below the last issued code, so that code ends last.
    assign start = rr_ptr - W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (load_en && sel_any) begin
            rr_ptr <= sel_idx;
        end
    end
`else
    assign start = W'(N - 1);
`endif

    pri_sel #(.N(N)) u_sel (
        .cand  (cand),
        .start (start),
        .any   (sel_any),
        .idx   (sel_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
        end else begin
            // Set wins over retire for the same bit.
            pending <= req | (pending & ~retire);
            if (load_en) begin
                if (sel_any) begin
                    out_valid <= 1'b1;
                    out_code  <= sel_idx;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign busy = (|pending) | out_valid;

endmodule

// File: tb/tb_pri_enc_seq.sv
module tb_pri_enc_seq;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_code;
    logic [3:0] pending;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [1:0] exp_q[$];
    logic [1:0] e;

    pri_enc_seq #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .pending   (pending),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge; sample and drive 1 time unit afterwards.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({pending, out_valid, out_code, busy} !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold[%0d]: pending=%b valid=%b code=%0d busy=%b, required all 0",
                         c, pending, out_valid, out_code, busy);
            end
        end
        rst_n = 1'b1;
        req = '0;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({pending, out_valid, busy} !== 6'b0) begin
                errors++;
                $display("FAIL reset_release[%0d]: pending=%b valid=%b busy=%b, required idle",
                         c, pending, out_valid, busy);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        exp_q.push_back(2'd2);
        step();
        req = '0;
        checks++;
        if (pending !== 4'b0100 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pend: pending=%b valid=%b, required 0100/0", pending, out_valid);
        end
        step();
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_code !== e || pending !== 4'b0000) begin
            errors++;
            $display("FAIL single_out: valid=%b code=%0d pending=%b, required 1/%0d/0000",
                     out_valid, out_code, pending, e);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: valid=%b busy=%b, required 0/0", out_valid, busy);
        end
    endtask

    // One request pattern, codes required on consecutive cycles from the queue.
    task automatic test_multi_pattern(input logic [3:0] pat, input int n);
        req = pat;
        step();
        req = '0;
        step();
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_code !== e) begin
                errors++;
                $display("FAIL multi_%b[%0d]: valid=%b code=%0d, required 1/%0d",
                         pat, k, out_valid, out_code, e);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL multi_%b_end: valid=%b busy=%b, required 0/0", pat, out_valid, busy);
        end
    endtask

    task automatic test_multi();
        do_reset();
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        test_multi_pattern(4'b1011, 3);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        test_multi_pattern(4'b1001, 2);
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        req = 4'b1000;
        exp_q.push_back(2'd3);
        step();
        req = '0;
        step();
        req = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_code !== 2'd3) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b code=%0d, required 1/3", c, out_valid, out_code);
            end
            req = (c % 2 == 1) ? 4'b0001 : 4'b0000;
        end
        req = '0;
        checks++;
        if (pending !== 4'b0001) begin
            errors++;
            $display("FAIL bp_pending: pending=%b, required 0001", pending);
        end
        out_ready = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (out_code !== e) begin
            errors++;
            $display("FAIL bp_accept: code=%0d, required %0d", out_code, e);
        end
        exp_q.push_back(2'd0);
        step();
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_code !== e) begin
            errors++;
            $display("FAIL bp_next: valid=%b code=%0d, required 1/%0d", out_valid, out_code, e);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_set_retire();
        do_reset();
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        req = 4'b0010;
        step();
        // req still high on the edge that loads bit 1
        step();
        req = '0;
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_code !== e || pending !== 4'b0010) begin
            errors++;
            $display("FAIL sr_load: valid=%b code=%0d pending=%b, required 1/%0d/0010",
                     out_valid, out_code, pending, e);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || pending !== 4'b0010) begin
            errors++;
            $display("FAIL sr_gap: valid=%b pending=%b, required 0/0010", out_valid, pending);
        end
        step();
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_code !== e || pending !== 4'b0000) begin
            errors++;
            $display("FAIL sr_reissue: valid=%b code=%0d pending=%b, required 1/%0d/0000",
                     out_valid, out_code, pending, e);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL sr_end: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        out_ready = 1'b0;
        req = 4'b1000;
        step();
        req = 4'b0110;
        step();
        req = '0;
        checks++;
        if (out_valid !== 1'b1 || out_code !== 2'd3 || pending !== 4'b0110) begin
            errors++;
            $display("FAIL mr_setup: valid=%b code=%0d pending=%b, required 1/3/0110",
                     out_valid, out_code, pending);
        end
        rst_n = 1'b0;
        req = 4'b1111;
        step();
        checks++;
        if ({pending, out_valid, out_code, busy} !== 8'h00) begin
            errors++;
            $display("FAIL mr_reset: pending=%b valid=%b code=%0d busy=%b, required all 0",
                     pending, out_valid, out_code, busy);
        end
        rst_n = 1'b1;
        req = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mr_stale[%0d]: valid=%b busy=%b, required 0/0", c, out_valid, busy);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_set_retire();
        test_midreset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d entries remain, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
